mem_arbiter: RTL and testbench

Shares one single-port unified memory between the core's instruction-fetch port and data port. It arbitrates the two requesters, holds the winning request on the memory bus until the memory acknowledges, returns read data with a one-cycle acknowledge pulse, and flags stuck accesses with a watchdog. It sits between the pipelined core (imem*/dmem* ports) and the memory model; core stall logic is driven from the inverse of the per-port acks.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/arb_watchdog.sv | 31 +++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the memory arbiter slice.
package arb_pkg;

  localparam int unsigned SIZE_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    IBUSY,
    DBUSY,
    RESP
  } arbState_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  // Access size code used for every instruction fetch (full word).
  localparam logic [SIZE_W-1:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: counts BUSY cycles and flags the last permitted cycle (count == TIMEOUT-1).
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned      CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // expire is registered alongside the count so it is valid in the same cycle as count == LAST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (clr) begin
      count  <= '0;
      expire <= (LAST == '0);
    end else if (en && (count != LAST)) begin
      count  <= count + CNT_W'(1);
      expire <= ((count + CNT_W'(1)) == LAST);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch and data ports.
// Define ARB_RR_EN for round-robin arbitration under contention; default is fixed data priority.
import arb_pkg::*;

module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iAck,
  output logic [DATA_W-1:0] iRdata,
  input  logic              dReq,
  input  logic              dWen,
  input  logic [SIZE_W-1:0] dSize,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic              dAck,
  output logic [DATA_W-1:0] dRdata,
  output logic              err,
  output logic              memReq,
  output logic              memWen,
  output logic [SIZE_W-1:0] memSize,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memReady
);

  arbState_t         state, stateNext;
  logic              memReqNext, memWenNext;
  logic [SIZE_W-1:0] memSizeNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [DATA_W-1:0] memWdataNext;
  logic              iAckNext, dAckNext, errNext;
  logic [DATA_W-1:0] iRdataNext, dRdataNext;
  logic              wdClr, wdEn, wdExpire;
  owner_t            grant;
  logic              grantValid;
`ifdef ARB_RR_EN
  owner_t            lastGrant, lastGrantNext;
`endif

  arb_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wdClr),
    .en     (wdEn),
    .expire (wdExpire)
  );

  // Data wins by default: it belongs to the older instruction in the pipeline.
  always_comb begin
    grantValid = dReq || iReq;
    grant      = dReq ? OWN_D : OWN_I;
`ifdef ARB_RR_EN
    if (dReq && iReq) begin
      grant = (lastGrant == OWN_D) ? OWN_I : OWN_D;
    end
`endif
  end

  always_comb begin
    stateNext    = state;
    memReqNext   = memReq;
    memWenNext   = memWen;
    memSizeNext  = memSize;
    memAddrNext  = memAddr;
    memWdataNext = memWdata;
    iAckNext     = 1'b0;
    dAckNext     = 1'b0;
    errNext      = 1'b0;
    iRdataNext   = iRdata;
    dRdataNext   = dRdata;
    wdClr        = 1'b0;
    wdEn         = 1'b0;
`ifdef ARB_RR_EN
    lastGrantNext = lastGrant;
`endif
    case (state)
      IDLE: begin
        if (grantValid) begin
          memReqNext = 1'b1;
          wdClr      = 1'b1;
          if (grant == OWN_D) begin
            stateNext    = DBUSY;
            memWenNext   = dWen;
            memSizeNext  = dSize;
            memAddrNext  = dAddr;
            memWdataNext = dWdata;
          end else begin
            stateNext    = IBUSY;
            memWenNext   = 1'b0;
            memSizeNext  = SIZE_WORD;
            memAddrNext  = iAddr;
            memWdataNext = '0;
          end
`ifdef ARB_RR_EN
          lastGrantNext = grant;
`endif
        end
      end
      IBUSY, DBUSY: begin
        wdEn = 1'b1;
        // A memReady in the final watchdog cycle takes precedence over the timeout.
        if (memReady || wdExpire) begin
          stateNext  = RESP;
          memReqNext = 1'b0;
          errNext    = !memReady;
          if (state == IBUSY) begin
            iAckNext   = 1'b1;
            iRdataNext = memReady ? memRdata : '0;
          end else begin
            dAckNext   = 1'b1;
            dRdataNext = (memReady && !memWen) ? memRdata : '0;
          end
        end
      end
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      memReq   <= 1'b0;
      memWen   <= 1'b0;
      memSize  <= '0;
      memAddr  <= '0;
      memWdata <= '0;
      iAck     <= 1'b0;
      dAck     <= 1'b0;
      err      <= 1'b0;
      iRdata   <= '0;
      dRdata   <= '0;
    end else begin
      state    <= stateNext;
      memReq   <= memReqNext;
      memWen   <= memWenNext;
      memSize  <= memSizeNext;
      memAddr  <= memAddrNext;
      memWdata <= memWdataNext;
      iAck     <= iAckNext;
      dAck     <= dAckNext;
      err      <= errNext;
      iRdata   <= iRdataNext;
      dRdata   <= dRdataNext;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastGrant <= OWN_I;
    end else begin
      lastGrant <= lastGrantNext;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench with a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          iReq = 1'b0, dReq = 1'b0, dWen = 1'b0, memReady = 1'b0;
  logic [AW-1:0] iAddr = '0, dAddr = '0;
  logic [2:0]    dSize = '0;
  logic [DW-1:0] dWdata = '0, memRdata = '0;
  logic          iAck, dAck, err, memReq, memWen;
  logic [DW-1:0] iRdata, dRdata, memWdata;
  logic [2:0]    memSize;
  logic [AW-1:0] memAddr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iRdata(iRdata),
    .dReq(dReq), .dWen(dWen), .dSize(dSize), .dAddr(dAddr), .dWdata(dWdata),
    .dAck(dAck), .dRdata(dRdata), .err(err),
    .memReq(memReq), .memWen(memWen), .memSize(memSize), .memAddr(memAddr),
    .memWdata(memWdata), .memRdata(memRdata), .memReady(memReady)
  );

  int nChecks = 0;
  int nErrors = 0;

  // Reference model: pending requests per port, last winner, last returned data, response phase.
  bit            pI = 0, pD = 0;
  logic [AW-1:0] iA = '0, dA = '0;
  logic          dW = 1'b0;
  logic [2:0]    dS = '0;
  logic [DW-1:0] dD = '0;
  bit            lastWasD = 0;
  bit            afterAck = 0;
  logic [DW-1:0] lastIr = '0, lastDr = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReqs();
    iReq = pI; iAddr = iA;
    dReq = pD; dWen = dW; dSize = dS; dAddr = dA; dWdata = dD;
  endtask

  task automatic newI(input logic [AW-1:0] a);
    pI = 1; iA = a;
  endtask

  task automatic newD(input logic w, input logic [2:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pD = 1; dW = w; dS = s; dA = a; dD = d;
  endtask

  task automatic idleStep();
    applyReqs();
    memReady = 1'($urandom_range(0, 1));
    memRdata = $urandom();
    tick();
    check("idleOut", {memReq, iAck, dAck, err}, 4'b0);
    afterAck = 0;
  endtask

  // One access: grant choice, memReq timing, held bus fields, ack cycle, data and err.
  task automatic serve(input int lat, input logic [DW-1:0] rd, output bit obsD);
    bit            expD, timedOut;
    int            kEnd;
    logic          expWen;
    logic [2:0]    expSize;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expData;
    expD     = (pD && pI) ? (RR ? !lastWasD : 1'b1) : pD;
    expWen   = expD ? dW : 1'b0;
    expSize  = expD ? dS : 3'b010;
    expAddr  = expD ? dA : iA;
    timedOut = (lat > int'(TO) - 1);
    kEnd     = timedOut ? int'(TO) - 1 : lat;
    applyReqs();
    memReady = 1'($urandom_range(0, 1));
    memRdata = $urandom();
    if (afterAck) begin
      tick();
      check("gapIdle", {memReq, iAck, dAck, err}, 4'b0);
      memReady = 1'($urandom_range(0, 1));
    end
    tick();
    check("reqRise", memReq, 1'b1);
    check("busFields", {memWen, memSize, memAddr}, {expWen, expSize, expAddr});
    check("memWdata", memWdata, expD ? dD : memWdata);
    for (int k = 0; k <= kEnd; k++) begin
      memReady = (k == lat);
      memRdata = (k == lat) ? rd : $urandom();
      tick();
      if (k < kEnd) begin
        check("busHold", {memReq, memWen, memSize, memAddr}, {1'b1, expWen, expSize, expAddr});
        check("earlyAck", {iAck, dAck, err}, 3'b0);
      end
    end
    expData = (timedOut || (expD && dW)) ? '0 : rd;
    if (expD) lastDr = expData; else lastIr = expData;
    check("ackOwner", {iAck, dAck}, {!expD, expD});
    check("err", err, timedOut);
    check("respReqLow", memReq, 1'b0);
    check("iRdata", iRdata, lastIr);
    check("dRdata", dRdata, lastDr);
    obsD     = dAck;
    lastWasD = expD;
    if (expD) pD = 0; else pI = 0;
    memReady = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 1) == 0) begin
      applyReqs();
      afterAck = 1;
    end else begin
      tick();
      check("respIdle", {memReq, iAck, dAck, err}, 4'b0);
      afterAck = 0;
    end
  endtask

  initial begin
    bit       o;
    bit [2:0] order;
    repeat (3) @(posedge clk);
    #1;
    check("rstCtl", {memReq, memWen, iAck, dAck, err}, 5'b0);
    check("rstBus", {memSize, memAddr, memWdata}, '0);
    check("rstData", {iRdata, dRdata}, '0);
    @(negedge clk) rst = 1'b1;
    tick();

    // Contention from reset: both requests held for three grants.
    newI(32'h0000_0400);
    newD(1'b0, 3'd2, 32'h0000_3000, $urandom());
    for (int i = 0; i < 3; i++) begin
      serve($urandom_range(0, 2), $urandom(), o);
      order[2 - i] = o;
      if (!pI) newI($urandom() & 32'hFFFF_FFFC);
      else if (!pD) newD(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), $urandom(), $urandom());
    end
    check("contentionOrder", order, RR ? 3'b101 : 3'b111);
    repeat (2) if (pI || pD) serve($urandom_range(0, 2), $urandom(), o);
    idleStep();

    // Fetch: data returned in the second BUSY cycle.
    newI(32'h0000_0100);
    serve(1, 32'h0050_0093, o);
    idleStep();

    // Store with immediate memReady.
    newD(1'b1, 3'd2, 32'h0000_2000, 32'hDEAD_BEEF);
    serve(0, $urandom(), o);
    idleStep();

    // Timeout, then memReady in the final watchdog cycle.
    newI(32'h0000_0200);
    serve(99, $urandom(), o);
    newD(1'b0, 3'd1, 32'h0000_0040, $urandom());
    serve(int'(TO) - 1, 32'h1234_5678, o);
    idleStep();

    // Random traffic.
    for (int n = 0; n < 80; n++) begin
      if (!pI && ($urandom_range(0, 2) != 0)) newI($urandom() & 32'hFFFF_FFFC);
      if (!pD && ($urandom_range(0, 2) != 0))
        newD(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), $urandom(), $urandom());
      if (pI || pD) serve($urandom_range(0, int'(TO) + 1), $urandom(), o);
      else idleStep();
    end
    while (pI || pD) serve($urandom_range(0, 2), $urandom(), o);
    idleStep();

    // Reset in the middle of a data access.
    newD(1'b1, 3'd0, 32'h0000_5000, 32'h0BAD_F00D);
    applyReqs();
    tick();
    check("rstMidBusy", memReq, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rstMidReq", memReq, 1'b0);
    check("rstMidAck", {dAck, iAck, err}, 3'b0);
    pD = 0;
    applyReqs();
    tick();
    check("rstHeld", {memReq, dAck, memAddr}, '0);
    @(negedge clk) rst = 1'b1;
    lastWasD = 0; afterAck = 0; lastIr = '0; lastDr = '0;
    tick();
    newI(32'h0000_0180);
    serve(2, 32'hCAFE_0001, o);
    idleStep();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
